// File: rtl/enclave_copy_engine.sv
// Responder side of the start-copy/done-copy handshake: copies len_words words
// from src_base to dst_base one word at a time over req/ack read and write ports.
module enclave_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  str_cpy,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  len_words,
  output logic                  done_cpy,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ack,
  output logic [2:0]            dbg_state
);

  // Handshake: a request (rd_req/wr_req) stays high with its address/data held
  // stable until the matching rd_valid/wr_ack is sampled high on a rising edge;
  // the acknowledge completes the transfer on that edge unless str_cpy is low.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WRITE    = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (str_cpy) begin
          src_d   = src_base;
          dst_d   = dst_base;
          rem_d   = len_words;
          cnt_d   = '0;
          state_d = (len_words == '0) ? S_DONE : S_READ;
        end
      end
      // An abort wins over an acknowledge arriving in the same cycle.
      S_READ: begin
        if (!str_cpy) begin
          state_d = S_IDLE;
        end else if (rd_valid) begin
          buf_d   = rd_data;
          src_d   = src_q + STRIDE;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!str_cpy) begin
          state_d = S_IDLE;
        end else if (wr_ack) begin
          dst_d   = dst_q + STRIDE;
          cnt_d   = cnt_q + LEN_WIDTH'(1);
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE:     state_d = S_WAIT_REL;
      S_WAIT_REL: if (!str_cpy) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pointers and buffer are registers, so the port values hold while waiting.
  assign rd_addr    = src_q;
  assign wr_addr    = dst_q;
  assign wr_data    = buf_q;
  assign words_done = cnt_q;
  assign rd_req     = (state_q == S_READ);
  assign wr_req     = (state_q == S_WRITE);
  assign done_cpy   = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_enclave_copy_engine.sv
// Scoreboard bench for enclave_copy_engine: a memory responder with
// configurable delays, expected read/write queues, and a decoupled monitor.
module tb_enclave_copy_engine;

  logic        aclk;
  logic        reset;
  logic        str_cpy;
  logic [31:0] src_base, dst_base;
  logic [15:0] len_words;
  logic        done_cpy, busy;
  logic [15:0] words_done;
  logic        rd_req, rd_valid, wr_req, wr_ack;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [2:0]  dbg_state;

  enclave_copy_engine dut (
    .aclk(aclk), .reset(reset), .str_cpy(str_cpy),
    .src_base(src_base), .dst_base(dst_base), .len_words(len_words),
    .done_cpy(done_cpy), .busy(busy), .words_done(words_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_q[$];
  logic [63:0] exp_q[$];
  int done_cnt = 0, done_cyc = 0, rd_cycles = 0, wr_cycles = 0;

  // reference memory: word at address a is pat_data + word offset from pat_addr
  logic [31:0] pat_addr, pat_data;
  int rd_delay = 0, wr_delay = 0;
  bit rand_mode = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return pat_data + ((a - pat_addr) >> 2);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] src, input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ra;
      ra = src + 32'(i * 4);
      rd_q.push_back(ra);
      exp_q.push_back({dst + 32'(i * 4), mem_word(ra)});
    end
  endtask

  // memory responder: acknowledges each request after a per-request delay
  initial begin
    int rd_cnt, rd_tgt, wr_cnt, wr_tgt;
    bit rd_act, wr_act;
    rd_valid = 1'b0; wr_ack = 1'b0; rd_data = '0;
    rd_act = 0; wr_act = 0; rd_cnt = 0; wr_cnt = 0; rd_tgt = 0; wr_tgt = 0;
    forever begin
      @(negedge aclk);
      rd_valid = 1'b0;
      wr_ack   = 1'b0;
      rd_data  = $urandom;
      if (rd_req) begin
        if (!rd_act) begin
          rd_act = 1; rd_cnt = 0;
          rd_tgt = rand_mode ? int'($urandom_range(0, 3)) : rd_delay;
        end
        if (rd_cnt == rd_tgt) begin
          rd_valid = 1'b1; rd_data = mem_word(rd_addr); rd_act = 0;
        end else rd_cnt++;
      end else rd_act = 0;
      if (wr_req) begin
        if (!wr_act) begin
          wr_act = 1; wr_cnt = 0;
          wr_tgt = rand_mode ? int'($urandom_range(0, 3)) : wr_delay;
        end
        if (wr_cnt == wr_tgt) begin
          wr_ack = 1'b1; wr_act = 0;
        end else wr_cnt++;
      end else wr_act = 0;
    end
  end

  // monitor: observes each cycle after inputs settle, before the next edge
  initial begin
    bit prev_rd, prev_wr;
    logic [31:0] prev_ra, prev_wa, prev_wd;
    prev_rd = 0; prev_wr = 0; prev_ra = '0; prev_wa = '0; prev_wd = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (reset) begin
        prev_rd = 0; prev_wr = 0;
      end else begin
        if (done_cpy) begin done_cnt++; done_cyc = cyc; end
        if (rd_req) rd_cycles++;
        if (wr_req) wr_cycles++;
        if (rd_req && prev_rd) chk("rd_addr_stable", rd_addr, prev_ra);
        if (wr_req && prev_wr) chk("wr_beat_stable", {wr_addr, wr_data}, {prev_wa, prev_wd});
        if (rd_req && rd_valid && str_cpy) begin
          n_vec++;
          if (rd_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_extra: got read at %0h expected none", rd_addr);
          end else begin
            logic [31:0] e;
            e = rd_q.pop_front();
            if (rd_addr !== e) begin
              n_err++;
              $display("FAIL rd_addr: got %0h expected %0h", rd_addr, e);
            end
          end
        end
        if (wr_req && wr_ack && str_cpy) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_extra: got write %0h<=%0h expected none", wr_addr, wr_data);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
              n_err++;
              $display("FAIL wr_beat: got %0h<=%0h expected %0h<=%0h",
                       wr_addr, wr_data, e[63:32], e[31:0]);
            end
          end
        end
        prev_rd = rd_req; prev_ra = rd_addr;
        prev_wr = wr_req; prev_wa = wr_addr; prev_wd = wr_data;
      end
    end
  end

  // driver tasks
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, output int d0, output int st);
    @(negedge aclk);
    src_base = src; dst_base = dst; len_words = len; str_cpy = 1'b1;
    d0 = done_cnt; st = cyc;
  endtask

  task automatic finish_copy(input int d0, input int st, input logic [15:0] len,
                             input bit chk_lat, input int hold);
    @(negedge aclk); #2;
    src_base = $urandom; dst_base = $urandom; len_words = 16'($urandom);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(negedge aclk); #2;
    end
    if (done_cnt == d0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done_cpy expected one pulse");
    end else begin
      if (chk_lat) chk("done_latency", 128'(done_cyc - st), 128'(2 * len + 1));
      chk("words_done", words_done, len);
    end
    repeat (hold) begin @(negedge aclk); #2; end
    chk("single_done", 128'(done_cnt), 128'(d0 + 1));
    chk("busy_held", busy, 1'b1);
    @(negedge aclk);
    str_cpy = 1'b0;
    @(negedge aclk); #2;
    chk("busy_released", busy, 1'b0);
    chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
    chk("wr_q_drained", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic copy(input logic [31:0] src, input logic [31:0] dst,
                      input logic [15:0] len, input bit chk_lat);
    int d0, st;
    pat_addr = src;
    push_exp(src, dst, int'(len));
    start_copy(src, dst, len, d0, st);
    finish_copy(d0, st, len, chk_lat, 3);
  endtask

  // stimulus
  initial begin
    int d0, st, rc, wc;
    bit hit;
    reset = 1'b1; str_cpy = 1'b1;
    src_base = 32'h2000; dst_base = 32'h9000; len_words = 16'd2;
    pat_addr = 32'h2000; pat_data = 32'h55;
    push_exp(32'h2000, 32'h9000, 2);
    repeat (5) begin
      @(negedge aclk); #2;
      chk("reset_outs", {done_cpy, busy, rd_req, wr_req, words_done, rd_addr, wr_addr, wr_data}, '0);
    end
    @(negedge aclk);
    reset = 1'b0; d0 = done_cnt; st = cyc;
    @(negedge aclk); #2;
    chk("start_rd_req", rd_req, 1'b1);
    finish_copy(d0, st, 16'd2, 1, 2);

    // zero-wait 4-word copy
    pat_data = 32'hA0;
    copy(32'h1000, 32'h8000, 16'd4, 1);

    // same copy with slow memory
    rd_delay = 3; wr_delay = 2;
    copy(32'h1000, 32'h8000, 16'd4, 0);
    rd_delay = 0; wr_delay = 0;

    // zero-length copy held high for 100 cycles
    rc = rd_cycles; wc = wr_cycles;
    pat_addr = 32'h3000;
    start_copy(32'h3000, 32'hC000, 16'd0, d0, st);
    finish_copy(d0, st, 16'd0, 1, 100);
    chk("len0_no_req", 128'({rd_cycles - rc, wr_cycles - wc}), '0);

    // abort while the 3rd write is pending, with wr_ack in the same cycle
    pat_addr = 32'h4000; pat_data = 32'h700;
    push_exp(32'h4000, 32'hD000, 2);
    rd_q.push_back(32'h4008);
    start_copy(32'h4000, 32'hD000, 16'd8, d0, st);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge aclk);
      if (wr_req && words_done == 16'd2) begin
        str_cpy = 1'b0; hit = 1;
      end
    end
    if (!hit) begin
      n_vec++; n_err++;
      $display("FAIL abort_setup: got no 3rd write expected one");
    end
    @(negedge aclk); #2;
    chk("abort_idle", {busy, wr_req, rd_req}, 3'b000);
    chk("abort_words_done", words_done, 16'd2);
    repeat (5) @(negedge aclk);
    #2;
    chk("abort_no_done", 128'(done_cnt), 128'(d0));
    chk("abort_words_kept", words_done, 16'd2);
    chk("abort_q_drained", 128'(rd_q.size() + exp_q.size()), '0);

    // address wrap
    pat_data = 32'h1234_0000;
    copy(32'hFFFF_FFF8, 32'h0000_5000, 16'd3, 1);

    // randomized copies with random memory delays
    rand_mode = 1;
    for (int k = 0; k < 6; k++) begin
      pat_data = $urandom;
      copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           16'($urandom_range(1, 10)), 0);
    end
    rand_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enclave_copy_engine.md
# enclave_copy_engine

Copy engine at the responder end of the security monitor's start-copy/done-copy handshake. When the monitor raises `str_cpy`, the engine copies `len_words` data words from a source region to the enclave memory region, one word at a time, over simple request/acknowledge read and write ports. It returns a one-cycle `done_cpy` pulse when the copy completes, then waits for the monitor to release the request.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of both memory ports.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8; address stride = DATA_WIDTH/8.
- `LEN_WIDTH`, 16: width of the word-count input.

Ports:
- `aclk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `str_cpy`  in  1  copy request level from the security monitor.
- `src_base`  in  ADDR_WIDTH  source byte address; sampled at start.
- `dst_base`  in  ADDR_WIDTH  enclave destination byte address; sampled at start.
- `len_words`  in  LEN_WIDTH  number of words to copy; sampled at start.
- `done_cpy`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from start until return to IDLE.
- `words_done`  out  LEN_WIDTH  count of words written in the current or last copy.
- `rd_req`  out  1  read request; held until `rd_valid`.
- `rd_addr`  out  ADDR_WIDTH  read byte address.
- `rd_valid`  in  1  read data valid; acknowledges `rd_req`.
- `rd_data`  in  DATA_WIDTH  read data.
- `wr_req`  out  1  write request; held until `wr_ack`.
- `wr_addr`  out  ADDR_WIDTH  write byte address.
- `wr_data`  out  DATA_WIDTH  write data.
- `wr_ack`  in  1  write accepted.

## Operation
- States: IDLE, READ, WRITE, DONE, WAIT_REL.
- IDLE: when `str_cpy`=1, latch `src_base`, `dst_base` and `len_words` into internal pointers and a remaining counter, and clear `words_done`. If the latched length is 0, go to DONE; otherwise go to READ.
- READ: `rd_req`=1, `rd_addr`=src pointer. On `rd_valid`=1, capture `rd_data` into a one-word buffer, advance the src pointer by DATA_WIDTH/8, and go to WRITE. `rd_valid` outside READ is ignored.
- WRITE: `wr_req`=1, `wr_addr`=dst pointer, `wr_data`=buffer. On `wr_ack`=1, advance the dst pointer, increment `words_done` and decrement the remaining count. If the remaining count was 1, go to DONE; otherwise go to READ.
- DONE: `done_cpy`=1 for exactly this one cycle, then go to WAIT_REL.
- WAIT_REL: stay until `str_cpy`=0, then go to IDLE. A request held high never starts a second copy.
- Abort: `str_cpy`=0 in READ or WRITE returns the engine to IDLE on the next edge.
  - No `done_cpy` is issued.
  - `words_done` keeps its partial value.
  - The abort takes priority over a `rd_valid`/`wr_ack` in the same cycle; the word is discarded or not counted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.
- `rd_req`, `wr_req`, `done_cpy` and `busy` are decoded from state. `busy` = (state ≠ IDLE).
- `rd_addr`, `wr_addr` and `wr_data` are registered and stable while their request is high.
- Base and length inputs changing mid-copy have no effect.

## Timing
- Reset values:
  - state IDLE.
  - `done_cpy`, `busy`, `rd_req`, `wr_req` = 0.
  - `words_done`, `rd_addr`, `wr_addr`, `wr_data` = 0.
- Reset mid-copy aborts immediately with no `done_cpy`.
- Start latency: if `str_cpy` is sampled high at edge k in IDLE, `rd_req` is high in the cycle after edge k.
- Throughput: 2 cycles/word minimum, when `rd_valid` and `wr_ack` are returned in the same cycle their request is first raised. The engine waits indefinitely for each acknowledge.
- Completion: `done_cpy` is high in the cycle after the edge that sampled the last `wr_ack`.
  - N words with zero-wait memory: `done_cpy` appears 2N+1 cycles after `str_cpy` is sampled.
  - `len_words`=0: `done_cpy` appears 1 cycle after `str_cpy` is sampled.
- Release: IDLE is reached one edge after `str_cpy`=0 is sampled in WAIT_REL. A new start is possible on the following edge.

## Test plan
- Reset held 5 cycles with `str_cpy`=1 → all outputs 0 throughout; after reset release, `rd_req`=1 one cycle later.
- src=0x1000, dst=0x8000, len=4, zero-wait memory, source words 0xA0..0xA3 → writes 0xA0..0xA3 to 0x8000/0x8004/0x8008/0x800C in order; `done_cpy` pulses once, 9 cycles after start; `words_done`=4.
- Same copy with 3-cycle `rd_valid` delay and 2-cycle `wr_ack` delay → addresses and data held stable while each request waits; identical memory contents; exactly one `done_cpy`.
- len=0 → no `rd_req` or `wr_req`; `done_cpy` pulses 1 cycle after start; `str_cpy` held 100 further cycles → no second pulse; `busy` stays 1 until `str_cpy` drops.
- len=8, `str_cpy` dropped while the 3rd write is pending, with `wr_ack` in the same cycle → IDLE next cycle; `done_cpy` never asserted; `words_done`=2.
- src=0xFFFFFFF8, len=3 → `rd_addr` sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; copy completes normally.
